// File: rtl/bus_burst_sram_slave.sv
// bus_burst_sram_slave: on-chip SRAM responder on the shared burst bus.
// Serves single/burst reads and writes; all outputs are zero when idle.
module bus_burst_sram_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter bit          WRITE_STALL  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        readNotWriteIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busyIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        endTransactionOut,
  output logic        busErrorOut,
  output logic        busyOut
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    READ_SETUP,
    READ_BURST,
    READ_END,
    WRITE,
    ERROR
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wordIndex;
  logic [3:0]            laneMask;
  logic [6:0]            issueLeft;
  logic [6:0]            beatsLeft;
  logic [31:0]           skidData0;
  logic [31:0]           skidData1;
  logic                  skidValid0;
  logic                  skidValid1;

  logic [31:0]           mem [DEPTH];

  logic                  hit;
  logic                  tooLong;
  logic [6:0]            beatTotal;
  logic [ADDR_WIDTH-1:0] startIndex;
  logic                  beatTransfer;
  logic                  issueRead;
  logic [31:0]           ramWord;
  logic [31:0]           fillData;
  logic                  acceptBeat;
  logic                  storeBeat;

  assign hit = beginTransactionIn &&
    (addressDataIn[31:ADDR_WIDTH+2] ==
     BASE_ADDRESS[31:ADDR_WIDTH+2]);
  assign tooLong    = |burstSizeIn[7:6];
  assign beatTotal  = {1'b0, burstSizeIn[5:0]} + 7'd1;
  assign startIndex = addressDataIn[ADDR_WIDTH+1:2];

  // A read is issued only while the skid has a free slot even
  // if the master stalls, so busyIn never gates the RAM port.
  assign beatTransfer = skidValid0 && !busyIn;
  assign issueRead = (state == READ_SETUP) ||
    ((state == READ_BURST) && (issueLeft != 7'd0) && !skidValid1);
  assign ramWord  = mem[wordIndex];
  assign fillData = issueRead ? ramWord : 32'd0;

  assign acceptBeat = (state == WRITE) && dataValidIn && !busyOut;
  assign storeBeat  = acceptBeat && (beatsLeft != 7'd0);

  assign addressDataOut = skidData0;
  assign dataValidOut   = skidValid0;

  // RAM write port with per-lane merge; contents survive reset.
  always_ff @(posedge clock) begin
    if (storeBeat) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (laneMask[lane]) begin
          mem[wordIndex][8*lane +: 8] <= addressDataIn[8*lane +: 8];
        end
      end
    end
  end

  // Bus FSM, read skid buffer and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      wordIndex         <= '0;
      laneMask          <= 4'd0;
      issueLeft         <= 7'd0;
      beatsLeft         <= 7'd0;
      skidData0         <= 32'd0;
      skidData1         <= 32'd0;
      skidValid0        <= 1'b0;
      skidValid1        <= 1'b0;
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      busyOut           <= 1'b0;
    end else begin
      endTransactionOut <= 1'b0;
      busErrorOut       <= 1'b0;
      busyOut           <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hit) begin
            wordIndex <= startIndex;
            laneMask  <= byteEnablesIn;
            issueLeft <= beatTotal;
            beatsLeft <= beatTotal;
            if (tooLong) begin
              busErrorOut       <= 1'b1;
              endTransactionOut <= 1'b1;
              state             <= ERROR;
            end else if (readNotWriteIn) begin
              state <= READ_SETUP;
            end else begin
              state <= WRITE;
            end
          end
        end
        READ_SETUP, READ_BURST: begin
          if (endTransactionIn) begin
            skidData0  <= 32'd0;
            skidData1  <= 32'd0;
            skidValid0 <= 1'b0;
            skidValid1 <= 1'b0;
            state      <= IDLE;
          end else begin
            if (issueRead) begin
              wordIndex <= wordIndex + 1'b1;
              issueLeft <= issueLeft - 7'd1;
            end
            if (beatTransfer) begin
              beatsLeft <= beatsLeft - 7'd1;
            end
            if (beatTransfer && (beatsLeft == 7'd1)) begin
              skidData0         <= 32'd0;
              skidData1         <= 32'd0;
              skidValid0        <= 1'b0;
              skidValid1        <= 1'b0;
              endTransactionOut <= 1'b1;
              state             <= READ_END;
            end else begin
              state <= READ_BURST;
              if (beatTransfer) begin
                if (skidValid1) begin
                  skidData0  <= skidData1;
                  skidValid0 <= 1'b1;
                  skidData1  <= fillData;
                  skidValid1 <= issueRead;
                end else begin
                  skidData0  <= fillData;
                  skidValid0 <= issueRead;
                end
              end else if (!skidValid0) begin
                skidData0  <= fillData;
                skidValid0 <= issueRead;
              end else if (issueRead) begin
                skidData1  <= ramWord;
                skidValid1 <= 1'b1;
              end
            end
          end
        end
        READ_END: begin
          state <= IDLE;
        end
        WRITE: begin
          if (acceptBeat) begin
            if (storeBeat) begin
              wordIndex <= wordIndex + 1'b1;
              beatsLeft <= beatsLeft - 7'd1;
            end else begin
              busErrorOut <= 1'b1;
            end
          end
          // The stall cycle also follows the closing beat.
          busyOut <= WRITE_STALL && acceptBeat;
          if (endTransactionIn) begin
            state <= IDLE;
          end
        end
        ERROR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
